// File: rtl/display_pkg.sv
// Shared constants, converter state type and anode lookup for the
// display_scan block and its binary-to-BCD converter.
package display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int MAX_VALUE  = 9999;
   localparam int BCD_W      = 4;
   localparam int BCD_FLD_W  = NUM_DIGITS * BCD_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } conv_state_e;

   // One-cold active-low anode pattern indexed by digit select (entry 0 = LSD).
   localparam logic [NUM_DIGITS-1:0][3:0] AN_ONE_COLD = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   function automatic logic [BCD_FLD_W-1:0] bcd_adjust(input logic [BCD_FLD_W-1:0] i_bcd);
      logic [BCD_FLD_W-1:0] v_out;
      v_out = i_bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i_bcd[i*BCD_W +: BCD_W] >= 4'd5)
            v_out[i*BCD_W +: BCD_W] = i_bcd[i*BCD_W +: BCD_W] + 4'd3;
      end
      return v_out;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter. Clamps the input to 9999, converts
// over VAL_W shift cycles and commits all four BCD digits at once. A
// one-deep pending slot (latest strobe wins) lets back-to-back updates
// chain without dropping busy.
module bin2bcd_seq
   import display_pkg::*;
#(
   parameter int VAL_W = 14
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst_n,
   input  logic [VAL_W-1:0]                       i_value,
   input  logic                                   i_valid,
   output logic                                   o_busy,
   output logic                                   o_ovf,
   output logic [NUM_DIGITS-1:0][BCD_W-1:0]       o_disp
);

   localparam int SR_W = BCD_FLD_W + VAL_W;
   localparam int IT_W = $clog2(VAL_W + 1);

   conv_state_e                       r_state;
   conv_state_e                       w_next;
   logic [SR_W-1:0]                   r_sr;
   logic [IT_W-1:0]                   r_iter;
   logic                              r_pend_v;
   logic [VAL_W-1:0]                  r_pend;
   logic                              r_pend_ovf;
   logic                              r_ovf;
   logic [NUM_DIGITS-1:0][BCD_W-1:0]  r_disp;

   logic                              w_in_ovf;
   logic [VAL_W-1:0]                  w_in_clamp;
   logic                              w_start;
   logic                              w_use_pend;
   logic [VAL_W-1:0]                  w_src_val;
   logic                              w_src_ovf;
   logic [SR_W-1:0]                   w_adj;

   assign w_in_ovf   = (32'(i_value) > 32'(MAX_VALUE));
   assign w_in_clamp = w_in_ovf ? VAL_W'(MAX_VALUE) : i_value;

   // A strobe arriving in COMMIT is newer than anything pending, so it wins.
   assign w_use_pend = (r_state == COMMIT) && !i_valid;
   assign w_src_val  = w_use_pend ? r_pend     : w_in_clamp;
   assign w_src_ovf  = w_use_pend ? r_pend_ovf : w_in_ovf;
   assign w_start    = ((r_state == IDLE) && i_valid) ||
                       ((r_state == COMMIT) && (i_valid || r_pend_v));

   assign w_adj = {bcd_adjust(r_sr[SR_W-1 -: BCD_FLD_W]), r_sr[VAL_W-1:0]};

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_valid) w_next = SHIFT;
         SHIFT:   if (r_iter == IT_W'(VAL_W - 1)) w_next = COMMIT;
         COMMIT:  w_next = (i_valid || r_pend_v) ? SHIFT : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs decoded from state: busy covers SHIFT and COMMIT.
   always_comb begin
      o_busy = (r_state != IDLE);
      o_ovf  = r_ovf;
      o_disp = r_disp;
   end

   // Shift register, iteration count, overflow flag and display commit.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sr   <= '0;
         r_iter <= '0;
         r_ovf  <= 1'b0;
         r_disp <= '0;
      end else begin
         if (w_start) begin
            r_sr   <= {{BCD_FLD_W{1'b0}}, w_src_val};
            r_iter <= '0;
            r_ovf  <= w_src_ovf;
         end else if (r_state == SHIFT) begin
            r_sr   <= {w_adj[SR_W-2:0], 1'b0};
            r_iter <= r_iter + 1'b1;
         end
         if (r_state == COMMIT)
            r_disp <= r_sr[SR_W-1 -: BCD_FLD_W];
      end
   end

   // Pending slot: filled by strobes during SHIFT, drained in COMMIT.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pend_v   <= 1'b0;
         r_pend     <= '0;
         r_pend_ovf <= 1'b0;
      end else if (i_valid && (r_state == SHIFT)) begin
         r_pend_v   <= 1'b1;
         r_pend     <= w_in_clamp;
         r_pend_ovf <= w_in_ovf;
      end else if (r_state == COMMIT) begin
         r_pend_v   <= 1'b0;
      end
   end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed display feeder: binary value -> BCD via
// bin2bcd_seq, then one digit per refresh slot with a one-cold active-low
// anode. Optional macro BLANK_LEAD_EN darkens leading-zero positions
// (digit 0 is always lit).
module display_scan
   import display_pkg::*;
#(
   parameter int VAL_W       = 14,
   parameter int REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [VAL_W-1:0]  value,
   input  logic              value_valid,
   output logic              busy,
   output logic              ovf,
   output logic [3:0]        digit,
   output logic [3:0]        an_n
);

   localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [NUM_DIGITS-1:0][BCD_W-1:0] w_disp;
   logic [PRE_W-1:0]                 r_pre;
   logic [1:0]                       r_sel;
   logic [3:0]                       r_digit;
   logic [3:0]                       r_an_n;
   logic [3:0]                       w_digit;
   logic [3:0]                       w_an_n;

   bin2bcd_seq #(.VAL_W(VAL_W)) u_conv (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_value (value),
      .i_valid (value_valid),
      .o_busy  (busy),
      .o_ovf   (ovf),
      .o_disp  (w_disp)
   );

   // Refresh prescaler; digit select advances on each terminal count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pre <= '0;
         r_sel <= 2'd0;
      end else if (r_pre == PRE_W'(REFRESH_DIV - 1)) begin
         r_pre <= '0;
         r_sel <= r_sel + 2'd1;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

`ifdef BLANK_LEAD_EN
   // Blank the slot when it and every more-significant digit are zero.
   always_comb begin
      logic v_upper_zero;
      v_upper_zero = 1'b1;
      w_digit      = w_disp[r_sel];
      w_an_n       = AN_ONE_COLD[r_sel];
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         v_upper_zero = v_upper_zero && (w_disp[i] == 4'd0);
         if ((r_sel == 2'(i)) && v_upper_zero)
            w_an_n = 4'b1111;
      end
   end
`else
   // All four positions lit in turn.
   always_comb begin
      w_digit = w_disp[r_sel];
      w_an_n  = AN_ONE_COLD[r_sel];
   end
`endif

   // Register the decoder-facing outputs every cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_digit <= 4'd0;
         r_an_n  <= 4'b1110;
      end else begin
         r_digit <= w_digit;
         r_an_n  <= w_an_n;
      end
   end

   assign digit = r_digit;
   assign an_n  = r_an_n;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan (REFRESH_DIV=4, VAL_W=14): directed
// scenarios followed by random strobes and resets, compared each cycle
// against a transaction-level model of conversion timing and scan position.
module tb_display_scan;

   localparam int VAL_W = 14;
   localparam int RD    = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             value_valid = 1'b0;
   logic [VAL_W-1:0] value = '0;
   logic             busy, ovf;
   logic [3:0]       digit, an_n;

   display_scan #(.VAL_W(VAL_W), .REFRESH_DIV(RD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .value_valid (value_valid),
      .busy        (busy),
      .ovf         (ovf),
      .digit       (digit),
      .an_n        (an_n)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model state: edges since reset, conversion in flight, pending, display.
   int k;
   bit m_act;
   int m_commit;
   int m_cur;
   bit m_ovf;
   bit m_pv;
   int m_pend;
   int m_disp;
   int p10 [4] = '{1, 10, 100, 1000};

   // A conversion started at edge k commits at edge k+VAL_W+1.
   task automatic model_start(input int v);
      m_cur    = (v > 9999) ? 9999 : v;
      m_ovf    = (v > 9999);
      m_commit = k + VAL_W + 1;
      m_act    = 1'b1;
   endtask

   task automatic cyc(input bit rst, input bit vv, input int v);
      int sel, dprev, e_dig, e_an;
      @(negedge clk);
      rst_n       = rst;
      value_valid = vv;
      value       = VAL_W'(v);
      @(posedge clk);
      #1;
      if (!rst) begin
         k = 0; m_act = 0; m_pv = 0; m_disp = 0; m_ovf = 0;
         e_dig = 0; e_an = 4'b1110;
      end else begin
         k++;
         sel   = ((k - 1) / RD) % 4;
         dprev = m_disp;
         if (vv) begin
            if (!m_act) model_start(v);
            else begin m_pv = 1; m_pend = v; end
         end
         if (m_act && k == m_commit) begin
            m_disp = m_cur;
            if (m_pv) begin m_pv = 0; model_start(m_pend); end
            else m_act = 0;
         end
         e_dig = (dprev / p10[sel]) % 10;
         e_an  = 15 & ~(1 << sel);
`ifdef BLANK_LEAD_EN
         if (sel > 0 && dprev < p10[sel]) e_an = 15;
`endif
      end
      chk("busy",  int'(busy),  int'(m_act));
      chk("ovf",   int'(ovf),   int'(m_ovf));
      chk("digit", int'(digit), e_dig);
      chk("an_n",  int'(an_n),  e_an);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0);
   endtask

   initial begin
      k = 0; m_act = 0; m_pv = 0; m_disp = 0; m_ovf = 0; m_commit = 0; m_cur = 0; m_pend = 0;
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      idle(20);
      // basic conversion and full scan
      cyc(1, 1, 1234);
      idle(40);
      // clamp and overflow, then a small value clears ovf
      cyc(1, 1, 12000);
      idle(30);
      cyc(1, 1, 7);
      idle(30);
      // strobes during busy: latest pending wins
      cyc(1, 1, 500);
      idle(3);
      cyc(1, 1, 42);
      idle(3);
      cyc(1, 1, 88);
      idle(50);
      // reset mid-conversion
      cyc(1, 1, 4321);
      idle(5);
      cyc(0, 0, 0);
      idle(20);
      // leading zeros and zero
      cyc(1, 1, 105);
      idle(40);
      cyc(1, 1, 0);
      idle(40);
      // strobe exactly in the COMMIT cycle chains a new conversion
      cyc(1, 1, 1111);
      idle(VAL_W);
      cyc(1, 1, 2222);
      idle(40);
      // random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         bit r, s;
         r = ($urandom_range(0, 199) != 0);
         s = ($urandom_range(0, 11) == 0);
         cyc(r, s, int'($urandom_range(0, 16383)));
      end
      idle(40);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
